mips150_mem_arbiter: RTL and testbench

Arbitrates the single synchronous block-RAM port shared by the MIPS150 instruction-fetch path and the load/store path. Each cycle it grants the port to one requester and drives the memory signals. It returns read data one cycle later, tagged to the owner. Data accesses win by default; a starvation counter guarantees fetch progress. A saturating conflict counter is exposed for performance debug.

---
 rtl/mips150_mem_pkg.sv | 14 +
 rtl/mips150_sat_counter.sv | 27 ++
 rtl/mips150_mem_arbiter.sv | 109 ++++++++++
 tb/tb_mips150_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips150_mem_pkg.sv
// Shared types and constants for the MIPS150 block-RAM port arbiter.
package mips150_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0]  WE_NONE    = 4'b0000;
    localparam int unsigned CONFLICT_W = 16;
    localparam int unsigned WAIT_W     = 4;

endpackage

// File: rtl/mips150_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes precedence over increment.
module mips150_sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mips150_mem_arbiter.sv
// Shares one synchronous block-RAM port between instruction fetch and load/store;
// data wins by default, a wait counter forces a fetch grant after MAX_WAIT denials.
module mips150_mem_arbiter
    import mips150_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic [3:0]            d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [CONFLICT_W-1:0] conflict_cnt
);

    logic [WAIT_W-1:0] w_wait_cnt;
    logic              w_fetch_pri;
    logic              w_i_gnt;
    logic              w_d_gnt;
    owner_t            r_owner;

    assign w_fetch_pri = (w_wait_cnt == WAIT_W'(MAX_WAIT));

    // Grant: single requester wins outright; on conflict data wins until fetch has starved.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!rst) begin
            if (i_req && (!d_req || w_fetch_pri)) begin
                w_i_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = WE_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_i_gnt) begin
            mem_addr  = i_addr;
        end else if (w_d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Owner of the read data returning next cycle; stores produce no response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else if (w_i_gnt) begin
            r_owner <= OWN_I;
        end else if (w_d_gnt && (d_we == WE_NONE)) begin
            r_owner <= OWN_D;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    assign mem_en   = w_i_gnt | w_d_gnt;
    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_rvalid = !rst && (r_owner == OWN_I);
    assign d_rvalid = !rst && (r_owner == OWN_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    mips150_sat_counter #(
        .WIDTH (WAIT_W),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (i_req & ~w_i_gnt),
        .i_clr (w_i_gnt | ~i_req),
        .o_cnt (w_wait_cnt)
    );

    mips150_sat_counter #(
        .WIDTH (CONFLICT_W),
        .MAX   ((1 << CONFLICT_W) - 1)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (i_req & d_req),
        .i_clr (1'b0),
        .o_cnt (conflict_cnt)
    );

endmodule

// File: tb/tb_mips150_mem_arbiter.sv
// Bench for mips150_mem_arbiter: directed vector table, hand sequences and a random run
// against a cycle-level reference model with its own shadow memory.
module tb_mips150_mem_arbiter;
    import mips150_mem_pkg::*;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned RAM_N    = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_gnt, i_rvalid;
    logic [DATA_W-1:0]     i_rdata;
    logic                  d_req;
    logic [3:0]            d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt, d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic [CONFLICT_W-1:0] conflict_cnt;

    always #5 clk = ~clk;

    mips150_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    // Synchronous byte-write RAM driven by the DUT, with a preload port.
    logic [DATA_W-1:0] ram [4096];
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_en) begin
            if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [4096];
    int                m_wait, m_conf;
    bit                m_pi, m_pd;
    logic [DATA_W-1:0] m_pdata;
    logic              e_ig, e_dg, e_iv, e_dv;
    logic [3:0]        e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic              rst, ireq;
        logic [ADDR_W-1:0] iaddr;
        logic              dreq;
        logic [3:0]        dwe;
        logic [ADDR_W-1:0] daddr;
        logic [DATA_W-1:0] dwdata;
        logic              eig, edg;
        logic [3:0]        emwe;
        logic              eiv, edv;
        logic [DATA_W-1:0] erd;
    } vec_t;

    vec_t vt [10];

    function automatic logic [DATA_W-1:0] init_val(input int a);
        if (a == 16) return 32'h2402_0005;
        if (a == 32) return 32'h0000_0000;
        return 32'hC0DE_0000 | DATA_W'(a);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [ADDR_W-1:0] ia,
                         input logic dr, input logic [3:0] dw, input logic [ADDR_W-1:0] da,
                         input logic [DATA_W-1:0] dd);
        rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    // Sample mid-cycle and compare every output with what the rules predict.
    task automatic sample(input bit chk);
        @(negedge clk);
        e_ig   = !rst && i_req && (!d_req || (m_wait >= int'(MAX_WAIT)));
        e_dg   = !rst && d_req && !e_ig;
        e_addr = e_ig ? i_addr : (e_dg ? d_addr : '0);
        e_wd   = e_dg ? d_wdata : '0;
        e_we   = e_dg ? d_we : 4'b0000;
        e_iv   = !rst && m_pi;
        e_dv   = !rst && m_pd;
        if (chk) begin
            check("cycle", 128'({i_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                                 i_rvalid, d_rvalid, conflict_cnt}),
                           128'({e_ig, e_dg, e_ig | e_dg, e_we, e_addr, e_wd,
                                 e_iv, e_dv, CONFLICT_W'(m_conf)}));
            if (e_iv) check("i_rdata", 128'(i_rdata), 128'(m_pdata));
            if (e_dv) check("d_rdata", 128'(d_rdata), 128'(m_pdata));
        end
    endtask

    // Advance the model across the rising edge using the inputs of the cycle just sampled.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_conf = 0; m_pi = 0; m_pd = 0;
        end else begin
            if (i_req && d_req && m_conf < 65535) m_conf++;
            if (i_req && !e_ig) m_wait = (m_wait + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait + 1;
            else                m_wait = 0;
            m_pi    = e_ig;
            m_pd    = e_dg && (d_we == 4'b0000);
            m_pdata = e_ig ? ref_mem[i_addr] : ref_mem[d_addr];
            if (e_dg)
                for (int b = 0; b < 4; b++)
                    if (d_we[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
        end
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 4'h0, '0, '0);
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        m_wait = 0; m_conf = 0; m_pi = 0; m_pd = 0; m_pdata = '0;
        #1;
        for (int a = 0; a < int'(RAM_N); a++) begin
            ld_en = 1'b1; ld_addr = ADDR_W'(a); ld_data = init_val(a);
            ref_mem[a] = init_val(a);
            @(posedge clk); #1;
        end
        ld_en = 1'b0;

        // Reset state: grants forced low even with both requests up.
        drive(1'b1, 1'b1, 12'h001, 1'b1, 4'h0, 12'h002, '0);
        sample(1'b1);
        check("rst_gnt", 128'({i_gnt, d_gnt, mem_en}), 128'(3'b000));
        check("rst_rvalid", 128'({i_rvalid, d_rvalid}), 128'(2'b00));
        advance();
        check("rst_conflict", 128'(conflict_cnt), 128'(0));

        // Directed table: single fetch, store then load, back-to-back fetches.
        vt[0] = '{1'b0, 1'b1, 12'h010, 1'b0, 4'h0, 12'h000, 32'h0,
                  1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0};
        vt[1] = '{1'b0, 1'b0, 12'h000, 1'b0, 4'h0, 12'h000, 32'h0,
                  1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h2402_0005};
        vt[2] = '{1'b0, 1'b0, 12'h000, 1'b1, 4'h3, 12'h020, 32'hAABB_CCDD,
                  1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 32'h0};
        vt[3] = '{1'b0, 1'b0, 12'h000, 1'b1, 4'h0, 12'h020, 32'h0,
                  1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 32'h0};
        vt[4] = '{1'b0, 1'b0, 12'h000, 1'b0, 4'h0, 12'h000, 32'h0,
                  1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0000_CCDD};
        for (int k = 0; k < 4; k++)
            vt[5+k] = '{1'b0, 1'b1, ADDR_W'(k), 1'b0, 4'h0, 12'h000, 32'h0,
                        1'b1, 1'b0, 4'h0, (k > 0), 1'b0, (k > 0) ? init_val(k-1) : 32'h0};
        vt[9] = '{1'b0, 1'b0, 12'h000, 1'b0, 4'h0, 12'h000, 32'h0,
                  1'b0, 1'b0, 4'h0, 1'b1, 1'b0, init_val(3)};

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].rst, vt[i].ireq, vt[i].iaddr, vt[i].dreq, vt[i].dwe, vt[i].daddr, vt[i].dwdata);
            sample(1'b1);
            check($sformatf("vec%0d_gnt", i), 128'({i_gnt, d_gnt}), 128'({vt[i].eig, vt[i].edg}));
            check($sformatf("vec%0d_mem_we", i), 128'(mem_we), 128'(vt[i].emwe));
            check($sformatf("vec%0d_rvalid", i), 128'({i_rvalid, d_rvalid}), 128'({vt[i].eiv, vt[i].edv}));
            if (vt[i].eiv) check($sformatf("vec%0d_i_rdata", i), 128'(i_rdata), 128'(vt[i].erd));
            if (vt[i].edv) check($sformatf("vec%0d_d_rdata", i), 128'(d_rdata), 128'(vt[i].erd));
            advance();
        end

        // Sustained conflict: four data grants then one fetch grant, repeating.
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 12'h005, 1'b1, 4'h0, 12'h006, '0);
            sample(1'b1);
            check($sformatf("conflict%0d_gnt", k), 128'({i_gnt, d_gnt}),
                  (k == 4 || k == 9) ? 128'(2'b10) : 128'(2'b01));
            advance();
        end
        drive(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0);
        sample(1'b1);
        check("conflict_cnt_10", 128'(conflict_cnt), 128'(10));
        advance();

        // Reset arriving while a fetch read is outstanding.
        drive(1'b0, 1'b1, 12'h006, 1'b1, 4'h0, 12'h007, '0);
        sample(1'b1);
        advance();
        drive(1'b0, 1'b1, 12'h001, 1'b0, 4'h0, '0, '0);
        sample(1'b1);
        check("rstmid_gnt", 128'(i_gnt), 128'(1));
        advance();
        drive(1'b1, 1'b1, 12'h002, 1'b0, 4'h0, '0, '0);
        sample(1'b1);
        check("rstmid_t1", 128'({i_gnt, i_rvalid, d_rvalid}), 128'(3'b000));
        advance();
        drive(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0);
        sample(1'b1);
        check("rstmid_t2", 128'({i_rvalid, d_rvalid}), 128'(2'b00));
        check("rstmid_conflict", 128'(conflict_cnt), 128'(0));
        advance();

        // Random traffic, including dropped requests and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(99) == 0),
                  ($urandom_range(2) != 0), ADDR_W'($urandom_range(RAM_N-1)),
                  ($urandom_range(2) != 0),
                  ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15)),
                  ADDR_W'($urandom_range(RAM_N-1)), DATA_W'($urandom));
            sample(1'b1);
            advance();
        end

        // Conflict counter saturation.
        drive(1'b1, 1'b0, '0, 1'b0, 4'h0, '0, '0);
        sample(1'b1);
        advance();
        for (int k = 0; k < 70000; k++) begin
            drive(1'b0, 1'b1, ADDR_W'(k % 8), 1'b1, 4'h0, ADDR_W'(8 + k % 8), '0);
            sample(k < 200 || k > 69900);
            advance();
        end
        drive(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0);
        sample(1'b1);
        check("conflict_sat", 128'(conflict_cnt), 128'(16'hFFFF));
        advance();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
